// File: rtl/fwrisc_tb_irq_gen_pkg.sv
// Shared register map for the fwrisc bench interrupt generator.
// Offsets are byte offsets within the 128-byte decode window.
package fwrisc_tb_irq_gen_pkg;

    localparam int unsigned WINDOW_BYTES = 128;
    localparam int unsigned OFF_WIDTH    = 7;

    typedef logic [OFF_WIDTH-1:0] byte_off_t;
    typedef logic [OFF_WIDTH-3:0] word_idx_t;

    localparam byte_off_t OFF_CNT0        = 7'h00;
    localparam byte_off_t OFF_ACK         = 7'h04;
    localparam byte_off_t OFF_STATUS      = 7'h08;
    localparam byte_off_t OFF_ENABLE      = 7'h0C;
    localparam byte_off_t OFF_CNT_BASE    = 7'h10;
    localparam byte_off_t OFF_RELOAD_BASE = 7'h30;

    // Word index of a byte offset; the low two address bits never matter.
    function automatic word_idx_t word_of(input byte_off_t off);
        return off[OFF_WIDTH-1:2];
    endfunction

endpackage

// File: rtl/fwrisc_tb_irq_chan.sv
// One interrupt channel: a software-loaded down-counter with an expiry pulse.
// Optional reload register enabled by FWRISC_TB_IRQ_GEN_PERIODIC_EN; without it
// the channel is one-shot and reload_val reads as zero.
module fwrisc_tb_irq_chan #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cnt_we,
    input  logic                 reload_we,
    input  logic [CNT_WIDTH-1:0] wdata,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] reload_val,
    output logic                 expire
);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] reload_q;

    // A software write on the terminal edge restarts the count instead of expiring.
    assign expire = (cnt == CNT_WIDTH'(1)) && !cnt_we;

`ifdef FWRISC_TB_IRQ_GEN_PERIODIC_EN
    // Reload value, loaded into the counter on every expiry.
    always_ff @(posedge clock) begin
        if (reset) begin
            reload_q <= '0;
        end else if (reload_we) begin
            reload_q <= wdata;
        end
    end
`else
    assign reload_q = '0;
`endif

    // Down-counter: write has priority, zero is the idle/hold state.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt_we) begin
            cnt <= wdata;
        end else if (expire) begin
            cnt <= reload_q;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_WIDTH'(1);
        end
    end

    assign count      = cnt;
    assign reload_val = reload_q;

endmodule

// File: rtl/fwrisc_tb_irq_gen.sv
// Bench-side multi-channel interrupt trigger on the fwrisc data bus.
// Decodes a 128-byte window at BASE_ADDR, holds pending/enable registers and
// the read mux; each channel counter lives in fwrisc_tb_irq_chan.
// Build option: FWRISC_TB_IRQ_GEN_PERIODIC_EN adds per-channel reload registers.
// Any nonzero byte strobe commits the whole word; all-zero strobes drop the write.
module fwrisc_tb_irq_gen
    import fwrisc_tb_irq_gen_pkg::*;
#(
    parameter int          N_CHANNELS = 4,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h40000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dvalid,
    input  logic                  dwrite,
    input  logic [31:0]           daddr,
    input  logic [31:0]           dwdata,
    input  logic [3:0]            dwstb,
    output logic                  hit,
    output logic                  dready,
    output logic [31:0]           drdata,
    output logic [N_CHANNELS-1:0] irq_vec,
    output logic                  irq
);

    logic [31:0]           rel_addr;
    word_idx_t             word;
    logic                  wr_en;
    logic                  ack_we;
    logic                  status_we;
    logic                  enable_we;

    logic [N_CHANNELS-1:0] cnt_we;
    logic [N_CHANNELS-1:0] reload_we;
    logic [N_CHANNELS-1:0] expire;
    logic [N_CHANNELS-1:0] pending;
    logic [N_CHANNELS-1:0] enable;
    logic [N_CHANNELS-1:0] clr_mask;

    logic [CNT_WIDTH-1:0]  cnt_val    [N_CHANNELS];
    logic [CNT_WIDTH-1:0]  reload_val [N_CHANNELS];
    logic [31:0]           cnt_rd     [N_CHANNELS];
    logic [31:0]           reload_rd  [N_CHANNELS];

    // Subtracting the base keeps the decode correct even for a base that is
    // not aligned to the window size.
    assign rel_addr  = daddr - BASE_ADDR;
    assign hit       = dvalid && (rel_addr < 32'(WINDOW_BYTES));
    assign dready    = hit;
    assign word      = word_of(rel_addr[OFF_WIDTH-1:0]);

    assign wr_en     = hit && dwrite && (dwstb != 4'b0000);
    assign ack_we    = wr_en && (word == word_of(OFF_ACK));
    assign status_we = wr_en && (word == word_of(OFF_STATUS));
    assign enable_we = wr_en && (word == word_of(OFF_ENABLE));

    generate
        for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
            // CNT0 is reachable both at the legacy offset and in the channel array.
            if (i == 0) begin : g_alias
                assign cnt_we[i] = wr_en &&
                    ((word == word_of(OFF_CNT0)) ||
                     (word == word_of(OFF_CNT_BASE) + word_idx_t'(i)));
            end else begin : g_plain
                assign cnt_we[i] = wr_en &&
                    (word == word_of(OFF_CNT_BASE) + word_idx_t'(i));
            end

            assign reload_we[i] = wr_en &&
                (word == word_of(OFF_RELOAD_BASE) + word_idx_t'(i));

            fwrisc_tb_irq_chan #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_chan (
                .clock      (clock),
                .reset      (reset),
                .cnt_we     (cnt_we[i]),
                .reload_we  (reload_we[i]),
                .wdata      (dwdata[CNT_WIDTH-1:0]),
                .count      (cnt_val[i]),
                .reload_val (reload_val[i]),
                .expire     (expire[i])
            );

            assign cnt_rd[i]    = 32'(cnt_val[i]);
            assign reload_rd[i] = 32'(reload_val[i]);
        end
    endgenerate

    // Clear mask from ACK (everything) or STATUS write-one-to-clear.
    always_comb begin
        clr_mask = '0;
        if (ack_we) begin
            clr_mask = '1;
        end else if (status_we) begin
            clr_mask = dwdata[N_CHANNELS-1:0];
        end
    end

    // Pending bits: an expiry on the same edge as a clear wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | expire;
        end
    end

    // Enable mask gates only the outputs; resets to all channels enabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            enable <= '1;
        end else if (enable_we) begin
            enable <= dwdata[N_CHANNELS-1:0];
        end
    end

    assign irq_vec = pending & enable;
    assign irq     = |irq_vec;

    // Read mux; unmapped offsets and ACK read as zero.
    always_comb begin
        drdata = '0;
        if (hit) begin
            if (word == word_of(OFF_CNT0)) begin
                drdata = cnt_rd[0];
            end else if (word == word_of(OFF_STATUS)) begin
                drdata[N_CHANNELS-1:0] = pending;
            end else if (word == word_of(OFF_ENABLE)) begin
                drdata[N_CHANNELS-1:0] = enable;
            end
            for (int i = 0; i < N_CHANNELS; i++) begin
                if (word == word_of(OFF_CNT_BASE) + word_idx_t'(i)) begin
                    drdata = cnt_rd[i];
                end
                if (word == word_of(OFF_RELOAD_BASE) + word_idx_t'(i)) begin
                    drdata = reload_rd[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_fwrisc_tb_irq_gen.sv
// Self-checking bench for fwrisc_tb_irq_gen (default parameters).
// Reference model tracks each channel as an absolute expiry time rather than
// a counter; live count is derived as (expiry time - current edge).
module tb_fwrisc_tb_irq_gen;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h40000000;
`ifdef FWRISC_TB_IRQ_GEN_PERIODIC_EN
    localparam bit PERIODIC = 1'b1;
`else
    localparam bit PERIODIC = 1'b0;
`endif

    logic          clock  = 1'b0;
    logic          reset  = 1'b1;
    logic          dvalid = 1'b0;
    logic          dwrite = 1'b0;
    logic [31:0]   daddr  = '0;
    logic [31:0]   dwdata = '0;
    logic [3:0]    dwstb  = '0;
    logic          hit;
    logic          dready;
    logic [31:0]   drdata;
    logic [N-1:0]  irq_vec;
    logic          irq;

    int n_vec = 0;
    int n_err = 0;

    fwrisc_tb_irq_gen #(
        .N_CHANNELS (N),
        .CNT_WIDTH  (16),
        .BASE_ADDR  (BASE)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .dvalid  (dvalid),
        .dwrite  (dwrite),
        .daddr   (daddr),
        .dwdata  (dwdata),
        .dwstb   (dwstb),
        .hit     (hit),
        .dready  (dready),
        .drdata  (drdata),
        .irq_vec (irq_vec),
        .irq     (irq)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    longint       m_edge;
    longint       m_exp [N];
    longint       m_rel [N];
    logic [N-1:0] m_pend;
    logic [N-1:0] m_en;

    function automatic void model_reset();
        m_edge = 0;
        for (int i = 0; i < N; i++) begin
            m_exp[i] = 0;
            m_rel[i] = 0;
        end
        m_pend = '0;
        m_en   = '1;
    endfunction

    function automatic logic [31:0] cnt_of(input int i);
        return (m_exp[i] != 0) ? 32'(m_exp[i] - m_edge) : 32'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] off);
        logic [31:0] w;
        w = off & 32'hFFFF_FFFC;
        if (w == 32'h0) return cnt_of(0);
        if (w == 32'h8) return 32'(m_pend);
        if (w == 32'hC) return 32'(m_en);
        for (int i = 0; i < N; i++) begin
            if (w == 32'h10 + 32'(4 * i)) return cnt_of(i);
            if (w == 32'h30 + 32'(4 * i)) return PERIODIC ? 32'(m_rel[i]) : 32'd0;
        end
        return 32'd0;
    endfunction

    function automatic void model_step(input logic v, input logic w, input logic [31:0] a,
                                       input logic [31:0] d, input logic [3:0] s);
        logic [31:0] off;
        logic [31:0] wo;
        bit          wr;
        bit          cw;
        logic [N-1:0] fired;
        logic [N-1:0] clr;
        off   = a - BASE;
        wo    = off & 32'hFFFF_FFFC;
        wr    = v && w && (s != 4'b0) && (off < 32'd128);
        fired = '0;
        clr   = '0;
        m_edge++;
        for (int i = 0; i < N; i++) begin
            cw = wr && ((wo == 32'h10 + 32'(4 * i)) || (i == 0 && wo == 32'h0));
            if (cw) begin
                m_exp[i] = (d[15:0] != 0) ? m_edge + longint'(d[15:0]) : 0;
            end else if (m_exp[i] == m_edge) begin
                fired[i] = 1'b1;
                m_exp[i] = (m_rel[i] != 0) ? m_edge + m_rel[i] : 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (PERIODIC && wr && wo == 32'h30 + 32'(4 * i)) m_rel[i] = longint'(d[15:0]);
        end
        if (wr && wo == 32'h4) clr = '1;
        else if (wr && wo == 32'h8) clr = d[N-1:0];
        m_pend = (m_pend & ~clr) | fired;
        if (wr && wo == 32'hC) m_en = d[N-1:0];
    endfunction

    // ---------------- checking helpers ----------------
    logic         last_hit;
    logic [31:0]  last_rd;
    logic [N-1:0] last_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive, compare against the model mid-cycle, clock, step model.
    task automatic do_cycle(input logic v, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        logic exp_hit;
        dvalid = v; dwrite = w; daddr = a; dwdata = d; dwstb = s;
        #2;
        exp_hit  = v && ((a - BASE) < 32'd128);
        last_hit = hit;
        last_rd  = drdata;
        last_vec = irq_vec;
        check("model_hit", 32'(hit), 32'(exp_hit));
        check("model_dready", 32'(dready), 32'(exp_hit));
        check("model_irq_vec", 32'(irq_vec), 32'(m_pend & m_en));
        check("model_irq", 32'(irq), 32'(|(m_pend & m_en)));
        if (!exp_hit || !w)
            check("model_drdata", drdata, exp_hit ? m_read(a - BASE) : 32'd0);
        @(posedge clock);
        model_step(v, w, a, d, s);
        #1;
        dvalid = 1'b0; dwrite = 1'b0; dwstb = 4'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        do_cycle(1'b1, 1'b1, BASE + off, d, 4'hF);
    endtask

    task automatic rd_chk(input logic [31:0] off, input logic [31:0] exp, input string name);
        do_cycle(1'b1, 1'b0, BASE + off, 32'd0, 4'h0);
        check(name, last_rd, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    endtask

    task automatic apply_reset();
        reset = 1'b1; dvalid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        v;
        logic        w;
        logic [31:0] off;
        logic [31:0] d;
        logic [3:0]  s;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_hit;
        logic [3:0]  exp_vec;
    } vec_t;

    vec_t tbl [24];

    initial begin
        logic [31:0] offs [17];
        logic [31:0] a;
        logic [31:0] d;
        int          sel;

        tbl[0]  = '{1, 0, 32'h0C, 0, 0, 1, 32'hF, 1, 0};
        tbl[1]  = '{1, 0, 32'h08, 0, 0, 1, 32'h0, 1, 0};
        tbl[2]  = '{1, 0, 32'h00, 0, 0, 1, 32'h0, 1, 0};
        tbl[3]  = '{1, 0, 32'h04, 0, 0, 1, 32'h0, 1, 0};
        tbl[4]  = '{1, 0, 32'h20, 0, 0, 1, 32'h0, 1, 0};
        tbl[5]  = '{1, 0, 32'h7C, 0, 0, 1, 32'h0, 1, 0};
        tbl[6]  = '{1, 0, 32'h80, 0, 0, 1, 32'h0, 0, 0};
        tbl[7]  = '{1, 0, 32'hFFFF_FFFC, 0, 0, 1, 32'h0, 0, 0};
        tbl[8]  = '{0, 0, 32'h0C, 0, 0, 1, 32'h0, 0, 0};
        tbl[9]  = '{1, 1, 32'h14, 32'h1234, 4'hF, 0, 0, 1, 0};
        tbl[10] = '{1, 0, 32'h14, 0, 0, 1, 32'h1234, 1, 0};
        tbl[11] = '{1, 0, 32'h14, 0, 0, 1, 32'h1233, 1, 0};
        tbl[12] = '{1, 1, 32'h14, 32'h99, 4'h0, 0, 0, 1, 0};
        tbl[13] = '{1, 0, 32'h14, 0, 0, 1, 32'h1231, 1, 0};
        tbl[14] = '{1, 1, 32'h0C, 32'h5, 4'h1, 0, 0, 1, 0};
        tbl[15] = '{1, 0, 32'h0C, 0, 0, 1, 32'h5, 1, 0};
        tbl[16] = '{1, 1, 32'h14, 32'h0, 4'hF, 0, 0, 1, 0};
        tbl[17] = '{1, 0, 32'h14, 0, 0, 1, 32'h0, 1, 0};
        tbl[18] = '{1, 1, 32'h0C, 32'hF, 4'hF, 0, 0, 1, 0};
        tbl[19] = '{1, 0, 32'h0E, 0, 0, 1, 32'hF, 1, 0};
        tbl[20] = '{1, 1, 32'h3C, 32'h7, 4'hF, 0, 0, 1, 0};
        tbl[21] = '{1, 0, 32'h3C, 0, 0, 1, PERIODIC ? 32'h7 : 32'h0, 1, 0};
        tbl[22] = '{1, 1, 32'h3C, 32'h0, 4'hF, 0, 0, 1, 0};
        tbl[23] = '{1, 1, 32'h24, 32'h3, 4'hF, 0, 0, 1, 0};

        apply_reset();
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_irq_vec", 32'(irq_vec), 32'd0);
        for (int i = 0; i < 24; i++) begin
            do_cycle(tbl[i].v, tbl[i].w, BASE + tbl[i].off, tbl[i].d, tbl[i].s);
            check("tbl_hit", 32'(last_hit), 32'(tbl[i].exp_hit));
            check("tbl_irq_vec", 32'(last_vec), 32'(tbl[i].exp_vec));
            if (tbl[i].chk_rd) check("tbl_rdata", last_rd, tbl[i].exp_rd);
        end
        idle(6);
        check("unmapped_cnt5_no_irq", 32'(irq), 32'd0);

        // 1 legacy single timer
        apply_reset();
        wr(32'h00, 5);
        idle(4);
        check("legacy_irq_before", 32'(irq), 32'd0);
        idle(1);
        check("legacy_irq_at5", 32'(irq), 32'd1);
        wr(32'h04, 0);
        check("legacy_ack", 32'(irq), 32'd0);

        // 2 multi-channel, W1C
        apply_reset();
        wr(32'h14, 3);
        wr(32'h18, 7);
        idle(2);
        rd_chk(32'h08, 32'h2, "multi_status_2");
        idle(4);
        rd_chk(32'h08, 32'h6, "multi_status_6");
        wr(32'h08, 32'h2);
        check("multi_w1c_vec", 32'(irq_vec), 32'h4);
        wr(32'h04, 0);

        // 3 mask
        apply_reset();
        wr(32'h0C, 0);
        wr(32'h00, 2);
        idle(2);
        rd_chk(32'h08, 32'h1, "mask_status");
        check("mask_irq_low", 32'(irq), 32'd0);
        wr(32'h0C, 1);
        check("mask_unmask_irq", 32'(irq), 32'd1);
        check("mask_unmask_vec", 32'(irq_vec), 32'h1);
        wr(32'h0C, 32'hF);
        wr(32'h04, 0);

        // 4 collisions
        apply_reset();
        wr(32'h1C, 3);
        idle(2);
        wr(32'h04, 0);
        rd_chk(32'h08, 32'h8, "coll_ack_set_wins");
        wr(32'h04, 0);
        wr(32'h00, 3);
        idle(2);
        wr(32'h00, 4);
        rd_chk(32'h08, 32'h0, "coll_write_wins");
        idle(2);
        check("coll_new_count_early", 32'(irq), 32'd0);
        idle(1);
        check("coll_new_count_fire", 32'(irq), 32'd1);
        wr(32'h04, 0);

        // 5 periodic reload
        apply_reset();
        wr(32'h30, 4);
        rd_chk(32'h30, PERIODIC ? 32'h4 : 32'h0, "per_reload_rd");
        wr(32'h00, 4);
        idle(3);
        check("per_first_early", 32'(irq), 32'd0);
        idle(1);
        check("per_first_fire", 32'(irq), 32'd1);
        for (int k = 0; k < 3; k++) begin
            wr(32'h04, 0);
            check("per_ack", 32'(irq), 32'd0);
            idle(2);
            check("per_between", 32'(irq), 32'd0);
            idle(1);
            check("per_repeat", 32'(irq), PERIODIC ? 32'd1 : 32'd0);
        end
        wr(32'h00, 0);
        wr(32'h04, 0);

        // 6 reset mid-count
        apply_reset();
        wr(32'h00, 10);
        idle(4);
        rd_chk(32'h00, 32'd6, "rst_cnt_before");
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        rd_chk(32'h00, 32'd0, "rst_cnt_after");
        for (int k = 0; k < 20; k++) begin
            idle(1);
            check("rst_no_irq", 32'(irq), 32'd0);
        end

        // randomized traffic against the model
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
                 32'h20, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h7C, 32'h80,
                 32'hFFFF_FFFC};
        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            sel = $urandom_range(0, 16);
            a   = BASE + offs[sel] + 32'($urandom_range(0, 3));
            d   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 12));
            do_cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < 55), a, d,
                     ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
